mbiobus_decoder: RTL and testbench

Address decoder and slave arbiter between the MicroBlaze MCS IO bus master and up to four IO bus slave peripherals. It registers each master transaction and forwards it to exactly one slave. It then waits for that slave's ready, and returns the read data and ready to the master. Unmapped addresses and unresponsive slaves are terminated with an error response, so the CPU never hangs on the IO bus.

---
 rtl/mbiobus_decoder.sv | 216 +++++++++++++++++++++
 tb/tb_mbiobus_decoder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbiobus_decoder.sv
// Address decoder and slave arbiter between the MicroBlaze MCS IO bus master
// and up to four IO bus slaves. Unmapped or silent slaves end in an error response.
module mbiobus_decoder #(
    parameter logic [31:0] BASE      = 32'hC000_0000,
    parameter logic [31:0] BASE_MASK = 32'hFFFF_C000,
    parameter int          SEL_LSB   = 12,
    parameter logic [3:0]  SLV_EN    = 4'b1111,
    parameter int          TIMEOUT   = 16,
    parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         io_addr_strobe,
    input  logic         io_read_strobe,
    input  logic         io_write_strobe,
    input  logic [3:0]   io_byte_en,
    input  logic [31:0]  io_addr,
    input  logic [31:0]  io_write_data,
    output logic [31:0]  io_read_data,
    output logic         io_ready,
    output logic [3:0]   s_addr_strobe,
    output logic [3:0]   s_read_strobe,
    output logic [3:0]   s_write_strobe,
    output logic [3:0]   s_byte_en,
    output logic [31:0]  s_addr,
    output logic [31:0]  s_write_data,
    input  logic [127:0] s_read_data,
    input  logic [3:0]   s_ready,
    output logic         bus_error,
    output logic [31:0]  err_addr
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic        wr_q, wr_d;
    logic [31:0] s_addr_q, s_addr_d;
    logic [3:0]  s_byte_en_q, s_byte_en_d;
    logic [31:0] s_write_data_q, s_write_data_d;
    logic [3:0]  s_addr_strobe_q, s_addr_strobe_d;
    logic [3:0]  s_read_strobe_q, s_read_strobe_d;
    logic [3:0]  s_write_strobe_q, s_write_strobe_d;
    logic        io_ready_q, io_ready_d;
    logic [31:0] io_read_data_q, io_read_data_d;
    logic        bus_error_q, bus_error_d;
    logic [31:0] err_addr_q, err_addr_d;

    logic [1:0]  idx_s;
    logic        hit_s;
    logic        rw_ok_s;
    logic        map_ok_s;
    logic        sel_ready_s;
    logic [31:0] sel_rdata_s;
    logic        drop_s;
    logic        term_err_s;
    logic [31:0] term_addr_s;

    assign idx_s       = io_addr[SEL_LSB+1:SEL_LSB];
    assign hit_s       = ((io_addr & BASE_MASK) == BASE);
    assign rw_ok_s     = io_read_strobe ^ io_write_strobe;
    assign map_ok_s    = hit_s & SLV_EN[idx_s] & rw_ok_s;
    // Only the latched slave's ready and data are ever looked at.
    assign sel_ready_s = s_ready[idx_q];
    assign sel_rdata_s = s_read_data[{idx_q, 5'd0} +: 32];
    assign drop_s      = io_addr_strobe & (state_q != ST_IDLE);

    // Next-state and next-output computation for the transaction FSM.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        idx_d            = idx_q;
        wr_d             = wr_q;
        s_addr_d         = s_addr_q;
        s_byte_en_d      = s_byte_en_q;
        s_write_data_d   = s_write_data_q;
        s_addr_strobe_d  = 4'b0000;
        s_read_strobe_d  = 4'b0000;
        s_write_strobe_d = 4'b0000;
        io_ready_d       = 1'b0;
        io_read_data_d   = 32'h0000_0000;
        term_err_s       = 1'b0;
        term_addr_s      = s_addr_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = 8'd0;
                if (io_addr_strobe) begin
                    s_addr_d       = io_addr;
                    s_byte_en_d    = io_byte_en;
                    s_write_data_d = io_write_data;
                    idx_d          = idx_s;
                    wr_d           = io_write_strobe;
                    term_addr_s    = io_addr;
                    if (map_ok_s) begin
                        state_d          = ST_ACCESS;
                        s_addr_strobe_d  = 4'b0001 << idx_s;
                        s_read_strobe_d  = io_read_strobe  ? (4'b0001 << idx_s) : 4'b0000;
                        s_write_strobe_d = io_write_strobe ? (4'b0001 << idx_s) : 4'b0000;
                    end else begin
                        state_d        = ST_RESP;
                        io_ready_d     = 1'b1;
                        term_err_s     = 1'b1;
                        io_read_data_d = io_write_strobe ? 32'h0000_0000 : ERR_DATA;
                    end
                end else begin
                    s_addr_d       = 32'h0000_0000;
                    s_byte_en_d    = 4'b0000;
                    s_write_data_d = 32'h0000_0000;
                end
            end
            ST_ACCESS: begin
                cnt_d = 8'd0;
                if (sel_ready_s) begin
                    state_d        = ST_RESP;
                    io_ready_d     = 1'b1;
                    io_read_data_d = wr_q ? 32'h0000_0000 : sel_rdata_s;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A ready arriving on the timeout edge still completes normally.
                if (sel_ready_s) begin
                    state_d        = ST_RESP;
                    io_ready_d     = 1'b1;
                    io_read_data_d = wr_q ? 32'h0000_0000 : sel_rdata_s;
                end else if (cnt_q == TO_LAST) begin
                    state_d        = ST_RESP;
                    io_ready_d     = 1'b1;
                    term_err_s     = 1'b1;
                    io_read_data_d = wr_q ? 32'h0000_0000 : ERR_DATA;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                state_d        = ST_IDLE;
                cnt_d          = 8'd0;
                s_addr_d       = 32'h0000_0000;
                s_byte_en_d    = 4'b0000;
                s_write_data_d = 32'h0000_0000;
            end
            default: begin
                state_d        = ST_IDLE;
                cnt_d          = 8'd0;
                s_addr_d       = 32'h0000_0000;
                s_byte_en_d    = 4'b0000;
                s_write_data_d = 32'h0000_0000;
            end
        endcase

        bus_error_d = term_err_s | drop_s;
        // A dropped strobe is the more recent event when both coincide.
        if (drop_s) begin
            err_addr_d = io_addr;
        end else if (term_err_s) begin
            err_addr_d = term_addr_s;
        end else begin
            err_addr_d = err_addr_q;
        end
    end

    // State and registered outputs, cleared asynchronously on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= ST_IDLE;
            cnt_q            <= 8'd0;
            idx_q            <= 2'd0;
            wr_q             <= 1'b0;
            s_addr_q         <= 32'h0000_0000;
            s_byte_en_q      <= 4'b0000;
            s_write_data_q   <= 32'h0000_0000;
            s_addr_strobe_q  <= 4'b0000;
            s_read_strobe_q  <= 4'b0000;
            s_write_strobe_q <= 4'b0000;
            io_ready_q       <= 1'b0;
            io_read_data_q   <= 32'h0000_0000;
            bus_error_q      <= 1'b0;
            err_addr_q       <= 32'h0000_0000;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            idx_q            <= idx_d;
            wr_q             <= wr_d;
            s_addr_q         <= s_addr_d;
            s_byte_en_q      <= s_byte_en_d;
            s_write_data_q   <= s_write_data_d;
            s_addr_strobe_q  <= s_addr_strobe_d;
            s_read_strobe_q  <= s_read_strobe_d;
            s_write_strobe_q <= s_write_strobe_d;
            io_ready_q       <= io_ready_d;
            io_read_data_q   <= io_read_data_d;
            bus_error_q      <= bus_error_d;
            err_addr_q       <= err_addr_d;
        end
    end

    assign io_read_data   = io_read_data_q;
    assign io_ready       = io_ready_q;
    assign s_addr_strobe  = s_addr_strobe_q;
    assign s_read_strobe  = s_read_strobe_q;
    assign s_write_strobe = s_write_strobe_q;
    assign s_byte_en      = s_byte_en_q;
    assign s_addr         = s_addr_q;
    assign s_write_data   = s_write_data_q;
    assign bus_error      = bus_error_q;
    assign err_addr       = err_addr_q;

endmodule

// File: tb/tb_mbiobus_decoder.sv
// Self-checking bench for mbiobus_decoder: directed scenarios plus random
// transactions compared against a latency/response model of the bus protocol.
module tb_mbiobus_decoder;

    localparam int          T        = 16;
    localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

    logic         clk = 1'b0;
    logic         rst;
    logic         io_addr_strobe, io_read_strobe, io_write_strobe;
    logic [3:0]   io_byte_en;
    logic [31:0]  io_addr, io_write_data;
    logic [31:0]  io_read_data;
    logic         io_ready;
    logic [3:0]   s_addr_strobe, s_read_strobe, s_write_strobe;
    logic [3:0]   s_byte_en;
    logic [31:0]  s_addr, s_write_data;
    logic [127:0] s_read_data;
    logic [3:0]   s_ready;
    logic         bus_error;
    logic [31:0]  err_addr;
    logic [145:0] all_out;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_err = 32'h0000_0000;

    mbiobus_decoder dut (
        .clk(clk), .rst(rst),
        .io_addr_strobe(io_addr_strobe), .io_read_strobe(io_read_strobe),
        .io_write_strobe(io_write_strobe), .io_byte_en(io_byte_en),
        .io_addr(io_addr), .io_write_data(io_write_data),
        .io_read_data(io_read_data), .io_ready(io_ready),
        .s_addr_strobe(s_addr_strobe), .s_read_strobe(s_read_strobe),
        .s_write_strobe(s_write_strobe), .s_byte_en(s_byte_en),
        .s_addr(s_addr), .s_write_data(s_write_data),
        .s_read_data(s_read_data), .s_ready(s_ready),
        .bus_error(bus_error), .err_addr(err_addr)
    );

    assign all_out = {io_read_data, io_ready, s_addr_strobe, s_read_strobe, s_write_strobe,
                      s_byte_en, s_addr, s_write_data, bus_error, err_addr};

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One master transaction; the slave raises ready so it is sampled 'delay'
    // edges after the access edge. drop_at >= 0 injects a stray master strobe.
    task automatic run_txn(input string tag, input logic [31:0] addr, input logic rd,
                           input logic wr, input logic [3:0] be, input logic [31:0] wdata,
                           input int delay, input logic [31:0] sdata,
                           input int drop_at, input logic [31:0] drop_addr);
        logic [1:0]   idx;
        logic [3:0]   sel, exp_as;
        logic         mapped, err, chk_data, exp_be;
        logic [31:0]  data, exp_rd;
        logic [127:0] rdbus;
        int           lat;
        idx      = addr[13:12];
        sel      = 4'b0001 << idx;
        mapped   = ((addr & 32'hFFFF_C000) == 32'hC000_0000) && (rd != wr);
        chk_data = (rd != wr);
        if (!mapped) begin
            lat = 0; err = 1'b1; data = wr ? 32'h0 : ERR_WORD;
        end else if (delay <= T) begin
            lat = 1 + delay; err = 1'b0; data = wr ? 32'h0 : sdata;
        end else begin
            lat = 1 + T; err = 1'b1; data = wr ? 32'h0 : ERR_WORD;
        end
        rdbus = {$urandom, $urandom, $urandom, $urandom};
        rdbus[idx*32 +: 32] = sdata;
        s_read_data     = rdbus;
        s_ready         = 4'b0000;
        io_addr         = addr;
        io_byte_en      = be;
        io_write_data   = wdata;
        io_read_strobe  = rd;
        io_write_strobe = wr;
        io_addr_strobe  = 1'b1;
        tick();
        io_read_strobe  = 1'b0;
        io_write_strobe = 1'b0;
        for (int k = 0; k <= lat; k++) begin
            s_ready = (4'($urandom) & ~sel) | ((mapped && k == delay) ? sel : 4'b0000);
            if (drop_at >= 0 && k == drop_at) begin
                io_addr_strobe = 1'b1;
                io_addr        = drop_addr;
            end else begin
                io_addr_strobe = 1'b0;
            end
            if (k == lat && err) model_err = addr;
            if (drop_at >= 0 && k == drop_at + 1) model_err = drop_addr;
            exp_be = (k == lat && err) || (drop_at >= 0 && k == drop_at + 1);
            exp_as = (mapped && k == 0) ? sel : 4'b0000;
            exp_rd = (k == lat) ? data : 32'h0;
            checks++;
            if (io_ready !== (k == lat)) begin
                errors++;
                $display("FAIL %s io_ready k=%0d got %b exp %b", tag, k, io_ready, (k == lat));
            end
            checks++;
            if (bus_error !== exp_be) begin
                errors++;
                $display("FAIL %s bus_error k=%0d got %b exp %b", tag, k, bus_error, exp_be);
            end
            checks++;
            if (err_addr !== model_err) begin
                errors++;
                $display("FAIL %s err_addr k=%0d got %h exp %h", tag, k, err_addr, model_err);
            end
            if (chk_data || k != lat) begin
                checks++;
                if (io_read_data !== exp_rd) begin
                    errors++;
                    $display("FAIL %s io_read_data k=%0d got %h exp %h", tag, k, io_read_data, exp_rd);
                end
            end
            checks++;
            if ({s_addr_strobe, s_read_strobe, s_write_strobe} !==
                {exp_as, rd ? exp_as : 4'b0000, wr ? exp_as : 4'b0000}) begin
                errors++;
                $display("FAIL %s strobes k=%0d got %h/%h/%h exp %h rd=%b wr=%b", tag, k,
                         s_addr_strobe, s_read_strobe, s_write_strobe, exp_as, rd, wr);
            end
            checks++;
            if ({s_addr, s_byte_en, s_write_data} !== {addr, be, wdata}) begin
                errors++;
                $display("FAIL %s shared_bus k=%0d got %h %h %h exp %h %h %h", tag, k,
                         s_addr, s_byte_en, s_write_data, addr, be, wdata);
            end
            tick();
        end
        s_ready        = 4'b0000;
        io_addr_strobe = 1'b0;
        checks++;
        if (all_out !== {114'd0, model_err}) begin
            errors++;
            $display("FAIL %s idle_after got %h exp err_addr %h only", tag, all_out, model_err);
        end
    endtask

    task automatic test_reset;
        repeat (3) tick();
        checks++;
        if (all_out !== 146'd0) begin
            errors++;
            $display("FAIL reset_state got %h exp 0", all_out);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        checks++;
        if (all_out !== 146'd0) begin
            errors++;
            $display("FAIL after_reset_release got %h exp 0", all_out);
        end
    endtask

    task automatic test_write_slave1;
        run_txn("write_s1", 32'hC000_1004, 1'b0, 1'b1, 4'hF, 32'h1234_5678, 0, 32'h0BAD_0001, -1, 32'h0);
    endtask

    task automatic test_read_slave3;
        run_txn("read_s3", 32'hC000_3000, 1'b1, 1'b0, 4'hF, 32'h0, 5, 32'hA5A5_0003, -1, 32'h0);
    endtask

    task automatic test_miss;
        run_txn("miss", 32'h8000_0000, 1'b1, 1'b0, 4'hF, 32'h0, 0, 32'h1111_1111, -1, 32'h0);
    endtask

    task automatic test_timeout;
        run_txn("timeout", 32'hC000_2000, 1'b1, 1'b0, 4'hF, 32'h0, 99, 32'h2222_2222, -1, 32'h0);
        s_ready = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({io_ready, bus_error, io_read_data} !== 34'd0) begin
                errors++;
                $display("FAIL late_ready cyc=%0d got rdy=%b err=%b data=%h exp 0", i, io_ready, bus_error, io_read_data);
            end
        end
        s_ready = 4'b0000;
        tick();
    endtask

    task automatic test_same_edge;
        run_txn("same_edge_rd", 32'hC000_2010, 1'b1, 1'b0, 4'h3, 32'h0, T, 32'h5A5A_0002, -1, 32'h0);
        run_txn("same_edge_wr", 32'hC000_0020, 1'b0, 1'b1, 4'hC, 32'hCAFE_F00D, T, 32'h0, -1, 32'h0);
    endtask

    task automatic test_drop;
        run_txn("drop", 32'hC000_0100, 1'b1, 1'b0, 4'h1, 32'h0, 6, 32'h7777_0000, 2, 32'hC000_1ABC);
    endtask

    task automatic test_bad_strobes;
        run_txn("both_rw", 32'hC000_1000, 1'b1, 1'b1, 4'hF, 32'h1, 0, 32'h3, -1, 32'h0);
        run_txn("neither_rw", 32'hC000_2004, 1'b0, 1'b0, 4'hF, 32'h1, 0, 32'h3, -1, 32'h0);
    endtask

    task automatic test_reset_mid;
        io_addr         = 32'hC000_1010;
        io_byte_en      = 4'hF;
        io_write_data   = 32'h0;
        io_read_strobe  = 1'b1;
        io_addr_strobe  = 1'b1;
        tick();
        io_addr_strobe  = 1'b0;
        io_read_strobe  = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        model_err = 32'h0;
        checks++;
        if (all_out !== 146'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs got %h exp 0", all_out);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        s_ready = 4'b0010;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (all_out !== 146'd0) begin
                errors++;
                $display("FAIL reset_mid_ready cyc=%0d got %h exp 0", i, all_out);
            end
        end
        s_ready = 4'b0000;
        tick();
        run_txn("after_reset", 32'hC000_1010, 1'b1, 1'b0, 4'hF, 32'h0, 2, 32'h1357_9BDF, -1, 32'h0);
    endtask

    task automatic test_random;
        logic [31:0] addr;
        logic        rd;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                addr = $urandom;
                if ((addr & 32'hFFFF_C000) == 32'hC000_0000) addr = addr ^ 32'h8000_0000;
            end else begin
                addr = 32'hC000_0000 | (32'($urandom_range(0, 3)) << 12) | ($urandom & 32'h0000_0FFC);
            end
            rd = 1'($urandom_range(0, 1));
            run_txn("random", addr, rd, ~rd, 4'($urandom), $urandom, $urandom_range(0, 20),
                    $urandom, -1, 32'h0);
        end
    endtask

    initial begin
        rst             = 1'b0;
        io_addr_strobe  = 1'b0;
        io_read_strobe  = 1'b0;
        io_write_strobe = 1'b0;
        io_byte_en      = 4'h0;
        io_addr         = 32'h0;
        io_write_data   = 32'h0;
        s_read_data     = 128'd0;
        s_ready         = 4'b0000;
        test_reset();
        test_write_slave1();
        test_read_slave3();
        test_miss();
        test_timeout();
        test_same_edge();
        test_drop();
        test_bad_strobes();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
